// File: rtl/ucode_pkg.sv
// rtl/ucode_pkg.sv - shared field positions, widths and state type for the microcode sequencer
package ucode_pkg;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int SEL_HI = 25;
  localparam int SEL_LO = 23;
  localparam int SEL_W  = SEL_HI - SEL_LO + 1;
  localparam int ROM_W  = 33;

  localparam logic [5:0]  MACRO_OPCODE_DEFAULT = 6'h3F;
  localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;
endpackage

// File: rtl/ucode_rom.sv
// rtl/ucode_rom.sv - constant micro-op table, combinational {last, instr} lookup
module ucode_rom
  import ucode_pkg::*;
#(
  parameter int          NUM_SLOTS  = 8,
  parameter int          SLOT_DEPTH = 8,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
  parameter int          ADDR_W     = $clog2(NUM_SLOTS * SLOT_DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ROM_W-1:0]  word
);
  logic [31:0] addr_ext;
  logic [31:0] slot;
  logic [31:0] idx;

  always_comb begin
    addr_ext = 32'(addr);
    slot     = addr_ext / 32'(SLOT_DEPTH);
    idx      = addr_ext % 32'(SLOT_DEPTH);
    // Anything not listed below is an unprogrammed word: a single NOP marked last.
    word     = {1'b1, NOP_INSTR};
    case (slot)
      32'd2: begin
        case (idx)
          32'd0:   word = {1'b0, 32'hA000_00A1};
          32'd1:   word = {1'b0, 32'hB000_00B2};
          32'd2:   word = {1'b1, 32'hC000_00C3};
          default: ;
        endcase
      end
      32'd5:   word = {1'b0, 32'hC500_0000 | idx};
      32'd6:   word = {1'b0, 32'hC600_0000 | idx};
      default: ;
    endcase
  end
endmodule

// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - macro-op detect, fetch stall and micro-op replay FSM
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter logic [5:0]  MACRO_OPCODE = MACRO_OPCODE_DEFAULT,
  parameter int          NUM_SLOTS    = 8,
  parameter int          SLOT_DEPTH   = 8,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] filtered_instruction,
  input  logic        instr_valid,
  input  logic        stall_in,
  output logic [31:0] ucode_instruction,
  output logic        control,
  output logic        fetch_stall,
  output logic        busy
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int UPC_W  = $clog2(SLOT_DEPTH);
  localparam int ADDR_W = SLOT_W + UPC_W;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [UPC_W-1:0]    upc_q, upc_d;
  logic                det;
  logic                end_uop;
  logic [SEL_W-1:0]    sel;
  logic [31:0]         sel_ext;
  logic [ROM_W-1:0]    rom_word;

  assign det     = instr_valid && (filtered_instruction[OP_HI:OP_LO] == MACRO_OPCODE);
  assign sel     = filtered_instruction[SEL_HI:SEL_LO];
  assign sel_ext = 32'(sel);

  ucode_rom #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_DEPTH(SLOT_DEPTH),
    .NOP_INSTR (NOP_INSTR),
    .ADDR_W    (ADDR_W)
  ) u_rom (
    .addr({slot_q, upc_q}),
    .word(rom_word)
  );

  // The slot boundary ends the sequence even if the table forgot the last bit.
  assign end_uop = rom_word[ROM_W-1] || (upc_q == UPC_W'(SLOT_DEPTH - 1));

  always_comb begin
    state_d           = state_q;
    slot_d            = slot_q;
    upc_d             = upc_q;
    ucode_instruction = NOP_INSTR;
    control           = 1'b0;
    fetch_stall       = 1'b0;
    busy              = 1'b0;
    case (state_q)
      IDLE: begin
        control     = det;
        fetch_stall = det;
        if (det && !stall_in) begin
          state_d = RUN;
          slot_d  = SLOT_W'(sel_ext % 32'(NUM_SLOTS));
          upc_d   = '0;
        end
      end
      RUN: begin
        control           = 1'b1;
        busy              = 1'b1;
        ucode_instruction = rom_word[31:0];
        fetch_stall       = !(end_uop && !stall_in);
        if (!stall_in) begin
          if (end_uop) begin
            state_d = IDLE;
            upc_d   = '0;
          end else begin
            upc_d = upc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A macro-op may still be held on the input during reset; keep the mux on pass-through.
    if (!rst_n) begin
      ucode_instruction = NOP_INSTR;
      control           = 1'b0;
      fetch_stall       = 1'b0;
      busy              = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      upc_q   <= upc_d;
    end
  end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb/tb_ucode_sequencer.sv - randomized and directed self-checking bench for ucode_sequencer
module tb_ucode_sequencer;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] UA  = 32'hA000_00A1;
  localparam logic [31:0] UB  = 32'hB000_00B2;
  localparam logic [31:0] UC  = 32'hC000_00C3;
  localparam logic [31:0] M2  = 32'hFD00_0000;
  localparam logic [31:0] M5  = 32'hFE80_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] filtered_instruction = '0;
  logic        instr_valid = 1'b0;
  logic        stall_in = 1'b0;
  logic [31:0] ucode_instruction;
  logic        control;
  logic        fetch_stall;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] uq[$];
  logic [31:0] src[$];
  logic [31:0] tr[$];
  logic [31:0] ft[$];

  always #5 clk = ~clk;

  ucode_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .filtered_instruction(filtered_instruction),
    .instr_valid         (instr_valid),
    .stall_in            (stall_in),
    .ucode_instruction   (ucode_instruction),
    .control             (control),
    .fetch_stall         (fetch_stall),
    .busy                (busy)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_word(int s, int k);
    if (s == 2 && k == 0) return {1'b0, UA};
    if (s == 2 && k == 1) return {1'b0, UB};
    if (s == 2 && k == 2) return {1'b1, UC};
    if (s == 5) return {1'b0, 32'hC500_0000 + 32'(k)};
    if (s == 6) return {1'b0, 32'hC600_0000 + 32'(k)};
    return {1'b1, NOP};
  endfunction

  function automatic void load_slot(int s);
    logic [32:0] w;
    uq.delete();
    for (int k = 0; k < 8; k++) begin
      w = ref_word(s, k);
      uq.push_back(w[31:0]);
      if (w[32]) break;
    end
  endfunction

  function automatic logic is_macro(logic v, logic [31:0] w);
    return v && (w[31:26] == 6'h3F);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) uq.delete();
    else if (!stall_in) begin
      if (uq.size() > 0) void'(uq.pop_front());
      else if (is_macro(instr_valid, filtered_instruction))
        load_slot(int'(filtered_instruction[25:23]));
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_u;
    logic        e_c, e_f, e_b, det;
    det = is_macro(instr_valid, filtered_instruction);
    if (!rst_n) begin
      e_u = NOP; e_c = 0; e_f = 0; e_b = 0;
    end else if (uq.size() > 0) begin
      e_u = uq[0]; e_c = 1; e_b = 1;
      e_f = !(uq.size() == 1 && !stall_in);
    end else begin
      e_u = NOP; e_c = det; e_f = det; e_b = 0;
    end
    chk("ucode_instruction", ucode_instruction, e_u);
    chk("control", 32'(control), 32'(e_c));
    chk("fetch_stall", 32'(fetch_stall), 32'(e_f));
    chk("busy", 32'(busy), 32'(e_b));
    if (rst_n && control) begin
      tr.push_back(ucode_instruction);
      ft.push_back(32'(fetch_stall));
    end
  end

  task automatic cyc(logic [31:0] w, logic v, logic s);
    filtered_instruction = w;
    instr_valid = v;
    stall_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(int max_cycles, int stall_pct, int gap_pct);
    int  n = 0;
    logic consume;
    while (src.size() > 0 && n < max_cycles) begin
      instr_valid = ($urandom_range(99) >= gap_pct);
      filtered_instruction = instr_valid ? src[0] : ($urandom & 32'h03FF_FFFF);
      stall_in = ($urandom_range(99) < stall_pct);
      @(negedge clk);
      consume = instr_valid && !fetch_stall;
      @(posedge clk);
      #1;
      if (consume) void'(src.pop_front());
      n++;
    end
    if (src.size() > 0) chk("feed_timeout_words_left", 32'(src.size()), 0);
    instr_valid = 0;
    stall_in = 0;
    src.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_trace(string name, logic [31:0] exp[$]);
    chk({name, "_len"}, 32'(tr.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tr.size(); i++) chk(name, tr[i], exp[i]);
  endtask

  initial begin
    logic [31:0] exp[$];
    logic [31:0] w;
    int hits;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_control", 32'(control), 0);
    chk("reset_fetch_stall", 32'(fetch_stall), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ucode", ucode_instruction, NOP);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;

    tr.delete(); ft.delete();
    src = '{32'h1234_5678, 32'h0000_0001};
    feed(20, 0, 0);
    chk("passthru_ctrl_cycles", 32'(tr.size()), 0);

    tr.delete(); ft.delete();
    src = '{M2};
    feed(20, 0, 0);
    exp = '{NOP, UA, UB, UC};
    chk_trace("slot2_seq", exp);
    exp = '{32'd1, 32'd1, 32'd1, 32'd0};
    chk("slot2_fs_len", 32'(ft.size()), 4);
    for (int i = 0; i < 4 && i < ft.size(); i++) chk("slot2_fetch_stall", ft[i], exp[i]);

    tr.delete(); ft.delete();
    cyc(M2, 1, 0);
    cyc(M2, 1, 0);
    cyc(M2, 1, 1);
    cyc(M2, 1, 1);
    cyc(M2, 1, 0);
    cyc(M2, 1, 0);
    cyc(32'h0, 0, 0);
    cyc(32'h0, 0, 0);
    exp = '{NOP, UA, UB, UB, UB, UC};
    chk_trace("stall_seq", exp);

    tr.delete(); ft.delete();
    src = '{M5};
    feed(40, 0, 0);
    exp = '{NOP};
    for (int k = 0; k < 8; k++) exp.push_back(32'hC500_0000 + 32'(k));
    chk_trace("slot5_seq", exp);
    hits = 0;
    foreach (tr[i]) if (tr[i][31:24] == 8'hC6) hits++;
    chk("no_slot6_word", 32'(hits), 0);

    tr.delete(); ft.delete();
    src = '{M2, M2};
    feed(40, 0, 0);
    exp = '{NOP, UA, UB, UC, NOP, UA, UB, UC};
    chk_trace("b2b_seq", exp);

    cyc(M2, 1, 0);
    rst_n = 0;
    #1;
    chk("abort_control", 32'(control), 0);
    chk("abort_fetch_stall", 32'(fetch_stall), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ucode", ucode_instruction, NOP);
    @(negedge clk);
    instr_valid = 0;
    #2 rst_n = 1;
    tr.delete();
    cyc(32'h1234_5678, 1, 0);
    cyc(32'h0000_0001, 1, 0);
    chk("post_reset_passthru", 32'(control), 0);
    chk("post_reset_no_resume", 32'(tr.size()), 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(99) < 40) begin
        w = {6'h3F, 3'($urandom_range(7)), 23'($urandom)};
      end else begin
        w = $urandom;
        if (w[31:26] == 6'h3F) w[26] = 1'b0;
      end
      src.push_back(w);
    end
    feed(5000, 25, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
